// File: rtl/vga_pkg.sv
// Shared VGA geometry, paddle dimensions and Pong ball-engine types.
package vga_pkg;

   localparam int unsigned HOR_PIXELS    = 1024;
   localparam int unsigned VER_PIXELS    = 768;
   localparam int unsigned PADDLE_H      = 100;
   localparam int unsigned PADDLE_W      = 15;
   localparam int unsigned PADDLE_MARGIN = 30;

   typedef enum logic [2:0] {IDLE, SERVE, MOVE, SCORED, OVER} ball_state_t;

   // Score increment that sticks at the game-ending value.
   function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
      return (s >= lim) ? lim : s + 4'd1;
   endfunction

endpackage

// File: rtl/frame_tick.sv
// One-clock pulse on each rising edge of vblnk; usable by any per-frame block.
module frame_tick (
   input  logic clk,
   input  logic rst,
   input  logic vblnk,
   output logic tick
);

   logic vblnk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q <= 1'b0;
         tick    <= 1'b0;
      end else begin
         vblnk_q <= vblnk;
         tick    <= vblnk & ~vblnk_q;
      end
   end

endmodule

// File: rtl/ball_ctl.sv
// Pong ball motion and game-state engine: per-frame ball update, wall and
// paddle reflection, miss detection, scoring and game-over handling.
module ball_ctl
   import vga_pkg::*;
#(
   parameter int unsigned BALL      = 16,
   parameter int unsigned SPEED_X   = 4,
   parameter int unsigned SPEED_Y   = 3,
   parameter int unsigned SERVE_FR  = 60,
   parameter int unsigned WIN_SCORE = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        start,
   input  logic [10:0] paddle_l_y,
   input  logic [10:0] paddle_r_y,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic [1:0]  point,
   output logic        game_over
);

   localparam int unsigned XW = 11;
   localparam int unsigned SW = 4;
   localparam int unsigned CW = $clog2(SERVE_FR);
   localparam int unsigned LF = PADDLE_MARGIN + PADDLE_W;
   localparam int unsigned RF = HOR_PIXELS - LF;

   localparam logic [XW-1:0] X_MID    = XW'((HOR_PIXELS - BALL) / 2);
   localparam logic [XW-1:0] Y_MID    = XW'((VER_PIXELS - BALL) / 2);
   localparam logic [XW-1:0] X_HIT_R  = XW'(RF - BALL);
   localparam logic [XW-1:0] X_HIT_L  = XW'(LF);
   localparam logic [XW-1:0] X_EDGE_R = XW'(HOR_PIXELS - BALL);
   localparam logic [XW-1:0] Y_FLOOR  = XW'(VER_PIXELS - BALL);
   localparam logic [SW-1:0] WIN      = SW'(WIN_SCORE);
   localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FR - 1);

   typedef logic signed [11:0] pos_t;
   localparam pos_t S_BALL = 12'(BALL);
   localparam pos_t S_SX   = 12'(SPEED_X);
   localparam pos_t S_SY   = 12'(SPEED_Y);
   localparam pos_t S_HOR  = 12'(HOR_PIXELS);
   localparam pos_t S_VER  = 12'(VER_PIXELS);
   localparam pos_t S_LF   = 12'(LF);
   localparam pos_t S_RF   = 12'(RF);
   localparam logic signed [12:0] W_PAD  = 13'(PADDLE_H);
   localparam logic signed [12:0] W_BALL = 13'(BALL);

   // Closed-interval overlap of the ball span with a paddle span; one extra bit avoids wrap.
   function automatic logic overlaps(input pos_t top, input logic [XW-1:0] py);
      logic signed [12:0] t;
      logic signed [12:0] p;
      t = {top[11], top};
      p = $signed({2'b00, py});
      return (t <= p + W_PAD) && (t + W_BALL >= p);
   endfunction

   ball_state_t     state, state_n;
   logic            tick;
   logic            dir_right, dir_right_n;
   logic            dir_down, dir_down_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [XW-1:0]   x_n, y_n;
   logic [SW-1:0]   sl_n, sr_n;
   logic [1:0]      point_n;
   logic            over_n;
   pos_t            sx, sy, nx, ny;
   logic            hit_r, hit_l;

   frame_tick u_frame_tick (
      .clk   (clk),
      .rst   (rst),
      .vblnk (vblnk),
      .tick  (tick)
   );

   assign sx    = $signed({1'b0, ball_x});
   assign sy    = $signed({1'b0, ball_y});
   assign nx    = dir_right ? sx + S_SX : sx - S_SX;
   assign ny    = dir_down  ? sy + S_SY : sy - S_SY;
   assign hit_r = dir_right  && (sx + S_BALL <= S_RF) && (nx + S_BALL > S_RF) && overlaps(ny, paddle_r_y);
   assign hit_l = !dir_right && (sx >= S_LF) && (nx < S_LF) && overlaps(ny, paddle_l_y);

   // Next-state, motion and scoring.
   always_comb begin
      state_n     = state;
      x_n         = ball_x;
      y_n         = ball_y;
      dir_right_n = dir_right;
      dir_down_n  = dir_down;
      cnt_n       = cnt;
      sl_n        = score_l;
      sr_n        = score_r;
      point_n     = 2'b00;
      over_n      = game_over;

      case (state)
         IDLE: begin
            x_n    = X_MID;
            y_n    = Y_MID;
            over_n = 1'b0;
            if (start) begin
               state_n = SERVE;
               sl_n    = '0;
               sr_n    = '0;
               cnt_n   = '0;
            end
         end
         SERVE: begin
            x_n = X_MID;
            y_n = Y_MID;
            if (tick) begin
               if (cnt == SERVE_LAST) begin
                  state_n = MOVE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         MOVE: begin
            if (tick) begin
               if (ny <= 12'sd0) begin
                  y_n        = '0;
                  dir_down_n = 1'b1;
               end else if (ny + S_BALL >= S_VER) begin
                  y_n        = Y_FLOOR;
                  dir_down_n = 1'b0;
               end else begin
                  y_n = ny[XW-1:0];
               end
               // A paddle hit wins over a miss on the same frame.
               if (hit_r) begin
                  x_n         = X_HIT_R;
                  dir_right_n = 1'b0;
               end else if (hit_l) begin
                  x_n         = X_HIT_L;
                  dir_right_n = 1'b1;
               end else if (nx + S_BALL >= S_HOR) begin
                  x_n         = X_EDGE_R;
                  point_n     = 2'b10;
                  sl_n        = sat_inc(score_l, WIN);
                  dir_right_n = 1'b1;
                  state_n     = SCORED;
               end else if (nx <= 12'sd0) begin
                  x_n         = '0;
                  point_n     = 2'b01;
                  sr_n        = sat_inc(score_r, WIN);
                  dir_right_n = 1'b0;
                  state_n     = SCORED;
               end else begin
                  x_n = nx[XW-1:0];
               end
            end
         end
         SCORED: begin
            x_n   = X_MID;
            y_n   = Y_MID;
            cnt_n = '0;
            if (score_l == WIN || score_r == WIN) begin
               state_n = OVER;
               over_n  = 1'b1;
            end else begin
               state_n = SERVE;
            end
         end
         OVER: begin
            x_n    = X_MID;
            y_n    = Y_MID;
            over_n = 1'b1;
            if (start) begin
               state_n = SERVE;
               sl_n    = '0;
               sr_n    = '0;
               cnt_n   = '0;
               over_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ball_x    <= X_MID;
         ball_y    <= Y_MID;
         dir_right <= 1'b1;
         dir_down  <= 1'b1;
         cnt       <= '0;
         score_l   <= '0;
         score_r   <= '0;
         point     <= 2'b00;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         ball_x    <= x_n;
         ball_y    <= y_n;
         dir_right <= dir_right_n;
         dir_down  <= dir_down_n;
         cnt       <= cnt_n;
         score_l   <= sl_n;
         score_r   <= sr_n;
         point     <= point_n;
         game_over <= over_n;
      end
   end

endmodule

// File: tb/tb_ball_ctl.sv
// Randomised game-play bench for ball_ctl against an integer model of the Pong rules.
module tb_ball_ctl;

   logic        clk;
   logic        rst;
   logic        vblnk;
   logic        start;
   logic [10:0] paddle_l_y;
   logic [10:0] paddle_r_y;
   logic [10:0] ball_x;
   logic [10:0] ball_y;
   logic [3:0]  score_l;
   logic [3:0]  score_r;
   logic [1:0]  point;
   logic        game_over;

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ball_ctl dut (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .start      (start),
      .paddle_l_y (paddle_l_y),
      .paddle_r_y (paddle_r_y),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .score_l    (score_l),
      .score_r    (score_r),
      .point      (point),
      .game_over  (game_over)
   );

   // Game model: phases, centre-referenced integer position, +1/-1 directions.
   localparam int P_IDLE = 0, P_SERVE = 1, P_MOVE = 2, P_OVER = 3;
   int m_phase, m_x, m_y, m_dx, m_dy, m_cnt, m_sl, m_sr;
   logic [1:0] m_point;

   function automatic void model_reset();
      m_phase = P_IDLE; m_x = 504; m_y = 376; m_dx = 1; m_dy = 1;
      m_cnt = 0; m_sl = 0; m_sr = 0; m_point = 2'b00;
   endfunction

   function automatic void model_start();
      if (m_phase == P_IDLE || m_phase == P_OVER) begin
         m_phase = P_SERVE; m_sl = 0; m_sr = 0; m_cnt = 0;
      end
   endfunction

   function automatic void model_score(input bit left);
      if (left) begin
         m_point = 2'b10; if (m_sl < 9) m_sl++; m_dx = 1;
      end else begin
         m_point = 2'b01; if (m_sr < 9) m_sr++; m_dx = -1;
      end
      m_x = 504; m_y = 376; m_cnt = 0;
      m_phase = (m_sl == 9 || m_sr == 9) ? P_OVER : P_SERVE;
   endfunction

   function automatic void model_tick(input int pl, input int pr);
      int nx, ny;
      m_point = 2'b00;
      if (m_phase == P_SERVE) begin
         if (m_cnt == 59) begin m_phase = P_MOVE; m_cnt = 0; end
         else m_cnt++;
      end else if (m_phase == P_MOVE) begin
         nx = m_x + 4 * m_dx;
         ny = m_y + 3 * m_dy;
         if (ny <= 0) begin m_y = 0; m_dy = 1; end
         else if (ny + 16 >= 768) begin m_y = 752; m_dy = -1; end
         else m_y = ny;
         if (m_dx > 0 && m_x + 16 <= 979 && nx + 16 > 979 && ny <= pr + 100 && ny + 16 >= pr) begin
            m_x = 963; m_dx = -1;
         end else if (m_dx < 0 && m_x >= 45 && nx < 45 && ny <= pl + 100 && ny + 16 >= pl) begin
            m_x = 45; m_dx = 1;
         end else if (nx + 16 >= 1024) model_score(1'b1);
         else if (nx <= 0) model_score(1'b0);
         else m_x = nx;
      end
   endfunction

   function automatic int track(input int y);
      int p;
      p = y - 40;
      if (p < 0) p = 0;
      if (p > 668) p = 668;
      return p;
   endfunction

   // One frame: vblnk high for 2 clocks, low for 4; records any point pulse seen.
   task automatic run_frame(input int pl, input int pr, output logic [1:0] pacc, output int pn);
      pacc = 2'b00; pn = 0;
      paddle_l_y = 11'(pl); paddle_r_y = 11'(pr); vblnk = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (point != 2'b00) begin pacc = pacc | point; pn++; end
         if (i == 1) vblnk = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; vblnk = 1'b0; start = 1'b0; paddle_l_y = '0; paddle_r_y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      total++; if (ball_x !== 11'd504) begin bad++; $display("FAIL reset_x got=%0d want=504", ball_x); end
      total++; if (ball_y !== 11'd376) begin bad++; $display("FAIL reset_y got=%0d want=376", ball_y); end
      total++; if (score_l !== 4'd0 || score_r !== 4'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d want=0/0", score_l, score_r); end
      total++; if (point !== 2'b00) begin bad++; $display("FAIL reset_point got=%b want=00", point); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%b want=0", game_over); end
   endtask

   task automatic test_idle();
      logic [1:0] pacc; int pn, pl, pr;
      for (int f = 0; f < 5; f++) begin
         pl = $urandom_range(0, 668); pr = $urandom_range(0, 668);
         run_frame(pl, pr, pacc, pn);
         model_tick(pl, pr);
         total++; if (ball_x !== 11'(m_x) || ball_y !== 11'(m_y)) begin bad++; $display("FAIL idle_pos f=%0d got=(%0d,%0d) want=(%0d,%0d)", f, ball_x, ball_y, m_x, m_y); end
         total++; if (score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin bad++; $display("FAIL idle_state f=%0d got=%0d/%0d over=%b want=0/0 over=0", f, score_l, score_r, game_over); end
         total++; if (pn != 0) begin bad++; $display("FAIL idle_point f=%0d got=%0d pulses want=0", f, pn); end
      end
   endtask

   task automatic test_serve();
      logic [1:0] pacc; int pn, pl, pr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_start();
      for (int t = 1; t <= 61; t++) begin
         pl = $urandom_range(0, 668); pr = $urandom_range(0, 668);
         run_frame(pl, pr, pacc, pn);
         model_tick(pl, pr);
         total++; if (ball_x !== 11'(m_x) || ball_y !== 11'(m_y)) begin bad++; $display("FAIL serve_pos t=%0d got=(%0d,%0d) want=(%0d,%0d)", t, ball_x, ball_y, m_x, m_y); end
         if (t == 61) begin
            total++; if (ball_x !== 11'd508 || ball_y !== 11'd379) begin bad++; $display("FAIL launch got=(%0d,%0d) want=(508,379)", ball_x, ball_y); end
         end
      end
      total++; if (score_l !== 4'd0 || score_r !== 4'd0) begin bad++; $display("FAIL serve_scores got=%0d/%0d want=0/0", score_l, score_r); end
   endtask

   task automatic test_rally();
      logic [1:0] pacc; int pn, pl, pr, frames;
      frames = 0;
      while (m_phase != P_OVER && frames < 8000) begin
         pl = ($urandom_range(0, 99) < 60) ? track(m_y) : int'($urandom_range(0, 668));
         pr = ($urandom_range(0, 99) < 10) ? track(m_y) : int'($urandom_range(0, 668));
         start = (m_phase == P_SERVE && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         run_frame(pl, pr, pacc, pn);
         model_tick(pl, pr);
         total++; if (ball_x !== 11'(m_x)) begin bad++; $display("FAIL rally_x fr=%0d got=%0d want=%0d", frames, ball_x, m_x); end
         total++; if (ball_y !== 11'(m_y)) begin bad++; $display("FAIL rally_y fr=%0d got=%0d want=%0d", frames, ball_y, m_y); end
         total++; if (score_l !== 4'(m_sl) || score_r !== 4'(m_sr)) begin bad++; $display("FAIL rally_score fr=%0d got=%0d/%0d want=%0d/%0d", frames, score_l, score_r, m_sl, m_sr); end
         total++; if (game_over !== ((m_phase == P_OVER) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL rally_over fr=%0d got=%b want=%0d", frames, game_over, m_phase == P_OVER); end
         total++; if (pacc !== m_point) begin bad++; $display("FAIL rally_point fr=%0d got=%b want=%b", frames, pacc, m_point); end
         total++; if (pn != ((m_point != 2'b00) ? 1 : 0)) begin bad++; $display("FAIL rally_pulse_len fr=%0d got=%0d want=%0d", frames, pn, (m_point != 2'b00) ? 1 : 0); end
         frames++;
      end
      start = 1'b0;
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL rally_end got over=%b want=1 after %0d frames", game_over, frames); end
   endtask

   task automatic test_over();
      logic [1:0] pacc; int pn, pl, pr;
      for (int f = 0; f < 3; f++) begin
         pl = $urandom_range(0, 668); pr = $urandom_range(0, 668);
         run_frame(pl, pr, pacc, pn);
         model_tick(pl, pr);
         total++; if (ball_x !== 11'd504 || ball_y !== 11'd376 || game_over !== 1'b1) begin bad++; $display("FAIL over_hold f=%0d got=(%0d,%0d) over=%b want=(504,376) over=1", f, ball_x, ball_y, game_over); end
         total++; if (score_l !== 4'(m_sl) || score_r !== 4'(m_sr)) begin bad++; $display("FAIL over_scores f=%0d got=%0d/%0d want=%0d/%0d", f, score_l, score_r, m_sl, m_sr); end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_start();
      total++; if (score_l !== 4'd0 || score_r !== 4'd0) begin bad++; $display("FAIL restart_scores got=%0d/%0d want=0/0", score_l, score_r); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_over got=%b want=0", game_over); end
   endtask

   task automatic test_reset_mid_move();
      logic [1:0] pacc; int pn, pl, pr, k;
      for (int f = 0; f < 66; f++) begin
         pl = track(m_y); pr = track(m_y);
         run_frame(pl, pr, pacc, pn);
         model_tick(pl, pr);
         total++; if (ball_x !== 11'(m_x) || ball_y !== 11'(m_y)) begin bad++; $display("FAIL premove_pos f=%0d got=(%0d,%0d) want=(%0d,%0d)", f, ball_x, ball_y, m_x, m_y); end
      end
      k = $urandom_range(0, 5);
      vblnk = 1'b1;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         if (i == 1) vblnk = 1'b0;
      end
      rst = 1'b1; vblnk = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      total++; if (ball_x !== 11'd504 || ball_y !== 11'd376) begin bad++; $display("FAIL midrst_pos k=%0d got=(%0d,%0d) want=(504,376)", k, ball_x, ball_y); end
      total++; if (score_l !== 4'd0 || score_r !== 4'd0 || point !== 2'b00 || game_over !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0d/%0d pt=%b over=%b want=0/0 pt=00 over=0", score_l, score_r, point, game_over); end
      for (int f = 0; f < 2; f++) begin
         run_frame(300, 300, pacc, pn);
         model_tick(300, 300);
         total++; if (ball_x !== 11'(m_x) || ball_y !== 11'(m_y)) begin bad++; $display("FAIL midrst_idle f=%0d got=(%0d,%0d) want=(%0d,%0d)", f, ball_x, ball_y, m_x, m_y); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_serve();
      test_rally();
      test_over();
      test_reset_mid_move();
      test_serve();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
